mpu_frame_assembler: RTL and testbench

Downstream consumer of the `mpu` I2C master's byte stream. It assembles each 14-byte burst read starting at register 0x3B into seven signed 16-bit big-endian words: accel X/Y/Z, temperature, and gyro X/Y/Z. It also runs a startup gyro-bias calibration and publishes bias-corrected, saturated gyro values. Its outputs feed the attitude-estimation stage with a one-cycle `frame_valid` strobe.

---
 rtl/mpu_pkg.sv | 40 ++++
 rtl/gyro_bias_cal.sv | 86 ++++++++
 rtl/mpu_frame_assembler.sv | 209 ++++++++++++++++++++
 tb/tb_mpu_frame_assembler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mpu_pkg                                                    |
// | Shared constants, word indices and FSM state type for the MPU        |
// | burst-read frame assembler.                                          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mpu_pkg;

  localparam int         MPU_FRAME_BYTES = 14;
  localparam logic [7:0] MPU_BURST_ADDR  = 8'h3B;

  // Word order inside one burst, big-endian words
  localparam int IDX_ACCEL_X = 0;
  localparam int IDX_ACCEL_Y = 1;
  localparam int IDX_ACCEL_Z = 2;
  localparam int IDX_TEMP    = 3;
  localparam int IDX_GYRO_X  = 4;
  localparam int IDX_GYRO_Y  = 5;
  localparam int IDX_GYRO_Z  = 6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2
  } mpu_state_t;

  // Clamp a 17-bit two's complement difference into signed 16-bit range
  function automatic logic [15:0] sat16(input logic [16:0] i_v);
    logic [15:0] w_res;
    if (i_v[16] != i_v[15]) begin
      w_res = i_v[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      w_res = i_v[15:0];
    end
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gyro_bias_cal.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gyro_bias_cal                                              |
// | Averages the raw gyro words of 2^CAL_LOG2 frames into a per-axis     |
// | bias. The previous bias is held until a new average is complete.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module gyro_bias_cal
  import mpu_pkg::*;
#(
  parameter int CAL_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_commit,
  input  logic             i_cal_start,
  input  logic [2:0][15:0] i_raw_gyro,
  output logic [2:0][15:0] o_bias,
  output logic             o_cal_done
);

  localparam int ACC_W = 16 + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] c_FRAMES_M1 = CNT_W'((1 << CAL_LOG2) - 1);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_acc_en;
  logic             w_last;

  assign w_acc_en   = i_commit & r_active & ~i_cal_start;
  assign w_last     = w_acc_en & (r_cnt == c_FRAMES_M1);
  assign o_cal_done = r_done;

  // Per-axis accumulator and bias register
  for (genvar ga = 0; ga < 3; ga++) begin : g_axis
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic [15:0]      r_bias;

    assign w_sum      = r_acc + {{CAL_LOG2{i_raw_gyro[ga][15]}}, i_raw_gyro[ga]};
    assign o_bias[ga] = r_bias;

    // Accumulate while calibrating; the bias takes bits above the shift,
    // which is the arithmetic right shift truncated to 16 bits
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc  <= '0;
        r_bias <= '0;
      end else if (i_cal_start) begin
        r_acc <= '0;
      end else if (w_acc_en) begin
        if (w_last) begin
          r_acc  <= '0;
          r_bias <= w_sum[CAL_LOG2 +: 16];
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  // Calibration sequencing: armed at reset, re-armed by i_cal_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else if (i_cal_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else if (w_acc_en) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
        r_done   <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mpu_frame_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mpu_frame_assembler                                        |
// | Collects 14-byte MPU bursts into seven signed words, applies gyro    |
// | bias correction with saturation and publishes a frame strobe.        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mpu_frame_assembler
  import mpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CAL_LOG2    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  input  logic        i_xfer_busy,
  input  logic        i_cal_start,
  output logic [15:0] o_accel_x,
  output logic [15:0] o_accel_y,
  output logic [15:0] o_accel_z,
  output logic [15:0] o_temp,
  output logic [15:0] o_gyro_x,
  output logic [15:0] o_gyro_y,
  output logic [15:0] o_gyro_z,
  output logic        o_frame_valid,
  output logic        o_frame_err,
  output logic        o_cal_done,
  output logic [15:0] o_frame_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      c_IDX_LAST = 4'(MPU_FRAME_BYTES - 1);

  mpu_state_t       r_state, w_state_nxt;
  logic [3:0]       r_byte_idx, w_idx_nxt, w_wr_idx;
  logic [TO_W-1:0]  r_idle_cnt, w_idle_nxt;
  logic             r_busy_d;
  logic             w_busy_rise, w_busy_fall;
  logic             w_store, w_commit, w_abort;
  logic [7:0]       r_bytes [MPU_FRAME_BYTES];
  logic [6:0][15:0] w_word;
  logic [2:0][15:0] w_gyro_raw, w_bias, w_gyro_corr;

  logic [15:0]      r_accel_x, r_accel_y, r_accel_z, r_temp;
  logic [2:0][15:0] r_gyro;
  logic             r_frame_valid, r_frame_err;
  logic [15:0]      r_frame_cnt;

  assign w_busy_rise = i_xfer_busy & ~r_busy_d;
  assign w_busy_fall = ~i_xfer_busy & r_busy_d;

  for (genvar gi = 0; gi < 7; gi++) begin : g_word
    assign w_word[gi] = {r_bytes[2*gi], r_bytes[2*gi+1]};
  end

  assign w_gyro_raw = w_word[IDX_GYRO_Z:IDX_GYRO_X];

  for (genvar ga = 0; ga < 3; ga++) begin : g_gyro
    logic [16:0] w_diff;
    assign w_diff          = {w_gyro_raw[ga][15], w_gyro_raw[ga]} - {w_bias[ga][15], w_bias[ga]};
    assign w_gyro_corr[ga] = sat16(w_diff);
  end

  gyro_bias_cal #(
    .CAL_LOG2 (CAL_LOG2)
  ) u_cal (
    .clk         (clk),
    .rst         (rst),
    .i_commit    (w_commit),
    .i_cal_start (i_cal_start),
    .i_raw_gyro  (w_gyro_raw),
    .o_bias      (w_bias),
    .o_cal_done  (o_cal_done)
  );

  // Byte FSM: next state, byte index, idle timer and abort detection
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_byte_idx;
    w_idle_nxt  = r_idle_cnt;
    w_wr_idx    = r_byte_idx;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle_nxt = '0;
        if (i_byte_valid) begin
          w_store     = 1'b1;
          w_wr_idx    = 4'd0;
          w_idx_nxt   = 4'd1;
          w_state_nxt = S_COLLECT;
        end else if (w_busy_rise) begin
          w_idx_nxt = 4'd0;
        end
      end
      S_COLLECT: begin
        if (w_busy_rise) begin
          // New burst mid-frame: drop the partial frame but keep collecting
          w_abort    = 1'b1;
          w_idle_nxt = '0;
          w_wr_idx   = 4'd0;
          w_store    = i_byte_valid;
          w_idx_nxt  = i_byte_valid ? 4'd1 : 4'd0;
        end else if (i_byte_valid && (r_byte_idx == c_IDX_LAST)) begin
          // Completing byte wins over a simultaneous end of burst
          w_store     = 1'b1;
          w_idle_nxt  = '0;
          w_idx_nxt   = 4'd0;
          w_state_nxt = S_COMMIT;
        end else if (w_busy_fall) begin
          w_abort     = 1'b1;
          w_idx_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (i_byte_valid) begin
          w_store    = 1'b1;
          w_idle_nxt = '0;
          w_idx_nxt  = r_byte_idx + 4'd1;
        end else if (r_idle_cnt == c_TO_LAST) begin
          w_abort     = 1'b1;
          w_idx_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end
      S_COMMIT: begin
        w_commit   = 1'b1;
        w_idle_nxt = '0;
        w_wr_idx   = 4'd0;
        if (i_byte_valid) begin
          w_store     = 1'b1;
          w_idx_nxt   = 4'd1;
          w_state_nxt = S_COLLECT;
        end else begin
          w_idx_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_idx_nxt   = 4'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state, byte index, idle timer and busy edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_idle_cnt <= '0;
      r_busy_d   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_idx <= w_idx_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_busy_d   <= i_xfer_busy;
    end
  end

  // Frame byte buffer; stale contents are always overwritten before use
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_bytes[w_wr_idx] <= i_byte_in;
    end
  end

  // Output registers, strobes and good-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accel_x     <= '0;
      r_accel_y     <= '0;
      r_accel_z     <= '0;
      r_temp        <= '0;
      r_gyro        <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_valid <= w_commit;
      r_frame_err   <= w_abort;
      if (w_commit) begin
        r_accel_x   <= w_word[IDX_ACCEL_X];
        r_accel_y   <= w_word[IDX_ACCEL_Y];
        r_accel_z   <= w_word[IDX_ACCEL_Z];
        r_temp      <= w_word[IDX_TEMP];
        r_gyro      <= w_gyro_corr;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign o_accel_x     = r_accel_x;
  assign o_accel_y     = r_accel_y;
  assign o_accel_z     = r_accel_z;
  assign o_temp        = r_temp;
  assign o_gyro_x      = r_gyro[0];
  assign o_gyro_y      = r_gyro[1];
  assign o_gyro_z      = r_gyro[2];
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mpu_frame_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mpu_frame_assembler                                     |
// | Bench for mpu_frame_assembler: directed scenarios plus random        |
// | frames checked against a word-level behavioural model.               |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_mpu_frame_assembler;

  localparam int TO = 20;
  localparam int CL = 1;
  localparam int NB = 14;

  typedef logic [7:0] frame_t [NB];
  typedef struct {
    logic [6:0][15:0] w;
    logic [15:0]      cnt;
    logic             done;
    int               t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_byte_in;
  logic        i_byte_valid, i_xfer_busy, i_cal_start;
  logic [15:0] o_accel_x, o_accel_y, o_accel_z, o_temp;
  logic [15:0] o_gyro_x, o_gyro_y, o_gyro_z, o_frame_cnt;
  logic        o_frame_valid, o_frame_err, o_cal_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  int exp_err  = 0;
  exp_t q[$];

  // Reference model state (integer arithmetic)
  int m_bias[3], m_sum[3];
  int m_n, m_cnt;
  bit m_active, m_done;

  mpu_frame_assembler #(
    .TIMEOUT_CYC (TO),
    .CAL_LOG2    (CL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_byte_in     (i_byte_in),
    .i_byte_valid  (i_byte_valid),
    .i_xfer_busy   (i_xfer_busy),
    .i_cal_start   (i_cal_start),
    .o_accel_x     (o_accel_x),
    .o_accel_y     (o_accel_y),
    .o_accel_z     (o_accel_z),
    .o_temp        (o_temp),
    .o_gyro_x      (o_gyro_x),
    .o_gyro_y      (o_gyro_y),
    .o_gyro_z      (o_gyro_z),
    .o_frame_valid (o_frame_valid),
    .o_frame_err   (o_frame_err),
    .o_cal_done    (o_cal_done),
    .o_frame_cnt   (o_frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 3; a++) begin
      m_bias[a] = 0;
      m_sum[a]  = 0;
    end
    m_n = 0; m_cnt = 0; m_active = 1'b1; m_done = 1'b0;
  endtask

  task automatic model_cal_start();
    for (int a = 0; a < 3; a++) m_sum[a] = 0;
    m_n = 0; m_active = 1'b1; m_done = 1'b0;
  endtask

  // Decode a good frame, apply the current bias, then fold it into calibration
  task automatic model_frame(input frame_t f, output exp_t e);
    int raw[7];
    int d, r, dv;
    dv = 1 << CL;
    for (int i = 0; i < 7; i++) begin
      raw[i] = int'(f[2*i]) * 256 + int'(f[2*i+1]);
      if (raw[i] >= 32768) raw[i] -= 65536;
    end
    for (int i = 0; i < 4; i++) e.w[i] = 16'(raw[i]);
    for (int a = 0; a < 3; a++) begin
      d = raw[4+a] - m_bias[a];
      if (d > 32767) d = 32767;
      else if (d < -32768) d = -32768;
      e.w[4+a] = 16'(d);
    end
    if (m_active) begin
      for (int a = 0; a < 3; a++) m_sum[a] += raw[4+a];
      m_n++;
      if (m_n == dv) begin
        for (int a = 0; a < 3; a++) begin
          r = m_sum[a] % dv;
          if (r < 0) r += dv;
          m_bias[a] = (m_sum[a] - r) / dv;
          m_sum[a]  = 0;
        end
        m_n = 0; m_active = 1'b0; m_done = 1'b1;
      end
    end
    m_cnt  = (m_cnt + 1) % 65536;
    e.cnt  = 16'(m_cnt);
    e.done = m_done;
    e.t    = cyc;
  endtask

  // Frame monitor: every strobe must match the oldest expected frame
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] obs [7];
    string nm [7];
    if (o_frame_err) err_cnt++;
    if (o_frame_valid) begin
      if (q.size() == 0) begin
        check_eq("fv_unexpected", 32'(o_frame_valid), 32'd0);
      end else begin
        e   = q.pop_front();
        obs = '{o_accel_x, o_accel_y, o_accel_z, o_temp, o_gyro_x, o_gyro_y, o_gyro_z};
        nm  = '{"accel_x", "accel_y", "accel_z", "temp", "gyro_x", "gyro_y", "gyro_z"};
        for (int k = 0; k < 7; k++) check_eq(nm[k], 32'(obs[k]), 32'(e.w[k]));
        check_eq("frame_cnt", 32'(o_frame_cnt), 32'(e.cnt));
        check_eq("cal_done", 32'(o_cal_done), 32'(e.done));
        check_eq("latency", 32'(cyc - e.t), 32'd2);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_byte_in    = b;
    i_byte_valid = 1'b1;
    @(negedge clk);
    i_byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input frame_t f, input int gap, input bit rnd);
    exp_t e;
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1) begin
        model_frame(f, e);
        q.push_back(e);
        send_byte(f[k], 0);
      end else begin
        send_byte(f[k], rnd ? int'($urandom_range(gap, 0)) : gap);
      end
    end
  endtask

  task automatic burst_frame(input frame_t f, input int gap);
    i_xfer_busy = 1'b1;
    @(negedge clk);
    send_frame(f, gap, 1'b0);
    repeat (2) @(negedge clk);
    i_xfer_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_frame(output frame_t f);
    for (int k = 0; k < NB; k++) f[k] = 8'($urandom);
  endtask

  task automatic gx_frame(input logic [15:0] gx, output frame_t f);
    rand_frame(f);
    f[8] = gx[15:8];
    f[9] = gx[7:0];
  endtask

  task automatic pulse_cal_start();
    i_cal_start = 1'b1;
    model_cal_start();
    @(negedge clk);
    i_cal_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check_eq("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    logic [15:0] snap;
    int e0;
    i_byte_in = '0; i_byte_valid = 1'b0; i_xfer_busy = 1'b0; i_cal_start = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_accel_x", 32'(o_accel_x), 32'd0);
    check_eq("rst_gyro_z", 32'(o_gyro_z), 32'd0);
    check_eq("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check_eq("rst_cal_done", 32'(o_cal_done), 32'd0);
    check_eq("rst_frame_valid", 32'(o_frame_valid), 32'd0);
    check_eq("rst_frame_err", 32'(o_frame_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed decode with 2-cycle gaps
    f = '{8'h00, 8'h10, 8'hFF, 8'hF0, 8'h40, 8'h00, 8'h12, 8'h34,
          8'h00, 8'h05, 8'hFF, 8'hFB, 8'h00, 8'h00};
    burst_frame(f, 2);
    wait_drain();
    check_eq("d_accel_x", 32'(o_accel_x), 32'h0010);
    check_eq("d_accel_y", 32'(o_accel_y), 32'hFFF0);
    check_eq("d_accel_z", 32'(o_accel_z), 32'h4000);
    check_eq("d_temp", 32'(o_temp), 32'h1234);
    check_eq("d_gyro_y", 32'(o_gyro_y), 32'hFFFB);
    check_eq("d_frame_cnt", 32'(o_frame_cnt), 32'd1);

    // Calibration 100/102 -> bias 101
    pulse_cal_start();
    @(negedge clk);
    check_eq("cal_restart_done", 32'(o_cal_done), 32'd0);
    gx_frame(16'd100, f); burst_frame(f, 1);
    gx_frame(16'd102, f); burst_frame(f, 1);
    wait_drain();
    check_eq("cal_done_rise", 32'(o_cal_done), 32'd1);
    gx_frame(16'd101, f); burst_frame(f, 1);
    wait_drain();
    check_eq("bias_gyro_x", 32'(o_gyro_x), 32'd0);

    // Saturation at -32768 with bias 100
    pulse_cal_start();
    gx_frame(16'd100, f); burst_frame(f, 0);
    gx_frame(16'd100, f); burst_frame(f, 0);
    gx_frame(16'h8000, f); burst_frame(f, 0);
    wait_drain();
    check_eq("sat_gyro_x", 32'(o_gyro_x), 32'h8000);

    // Busy falls after 7 bytes
    snap = o_accel_x;
    e0 = err_cnt;
    i_xfer_busy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 7; k++) send_byte(8'($urandom), 1);
    i_xfer_busy = 1'b0;
    repeat (3) @(negedge clk);
    exp_err++;
    check_eq("fall_err", 32'(err_cnt - e0), 32'd1);
    check_eq("fall_hold_ax", 32'(o_accel_x), 32'(snap));
    check_eq("fall_hold_cnt", 32'(o_frame_cnt), 32'(m_cnt));
    rand_frame(f); burst_frame(f, 1);
    wait_drain();

    // Idle timeout after 5 bytes
    e0 = err_cnt;
    i_xfer_busy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 0);
    repeat (25) @(negedge clk);
    exp_err++;
    check_eq("timeout_err", 32'(err_cnt - e0), 32'd1);
    i_xfer_busy = 1'b0;
    repeat (2) @(negedge clk);
    rand_frame(f); burst_frame(f, 1);
    wait_drain();
    check_eq("timeout_once", 32'(err_cnt - e0), 32'd1);

    // Busy rises mid-frame together with byte 0 of a new frame
    e0 = err_cnt;
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
    i_xfer_busy = 1'b1;
    rand_frame(f);
    send_frame(f, 1, 1'b0);
    repeat (2) @(negedge clk);
    i_xfer_busy = 1'b0;
    wait_drain();
    exp_err++;
    check_eq("rise_err", 32'(err_cnt - e0), 32'd1);

    // Reset after byte 9, then a clean frame
    e0 = err_cnt;
    i_xfer_busy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) send_byte(8'($urandom), 1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("midrst_cnt", 32'(o_frame_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rand_frame(f); send_frame(f, 1, 1'b0);
    repeat (2) @(negedge clk);
    i_xfer_busy = 1'b0;
    wait_drain();
    check_eq("midrst_frame_cnt", 32'(o_frame_cnt), 32'd1);
    check_eq("midrst_no_err", 32'(err_cnt - e0), 32'd0);

    // Random frames, including back-to-back and calibration restarts
    i_xfer_busy = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(5, 0) == 0) begin
        wait_drain();
        pulse_cal_start();
      end
      rand_frame(f);
      send_frame(f, 2, 1'b1);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_drain();
    i_xfer_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("err_total", 32'(err_cnt), 32'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
